mem_access_unit: RTL and testbench

Initiator-side memory access unit that sits between the CPU load/store datapath and the `ram` block. It accepts one load or store request at a time over a valid/ready handshake, range-checks it, and drives the RAM's enable/write/size/address/data ports. It captures the RAM's registered read data, sign- or zero-extends byte loads, and returns a response over a second valid/ready handshake.

---
 rtl/mem_pkg.sv | 26 ++
 rtl/mem_load_format.sv | 22 ++
 rtl/mem_access_unit.sv | 139 +++++++++++++
 tb/tb_mem_access_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared memory-side definitions: size encodings, address limit, access-unit
// FSM encoding and the latched request control fields.
package mem_pkg;

    localparam int unsigned MEM_ADDR_W     = 16;
    localparam int unsigned MEM_DATA_W     = 16;
    localparam int unsigned MEM_ADDR_LIMIT = 2048;

    localparam logic [1:0] MEM_SIZE_BYTE = 2'd1;
    localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } mem_state_e;

    // Request fields still needed after the RAM command has been issued
    typedef struct packed {
        logic       write;
        logic [1:0] size;
        logic       sign;
    } mem_ctl_t;

endpackage

// File: rtl/mem_load_format.sv
// Size/sign formatting of raw RAM read data.
//   size      : MEM_SIZE_BYTE or MEM_SIZE_WORD
//   is_signed : sign-extend byte loads
//   raw       : RAM read data
//   data_c    : formatted load data (combinational)
module mem_load_format
    import mem_pkg::*;
(
    input  logic [1:0]            size,
    input  logic                  is_signed,
    input  logic [MEM_DATA_W-1:0] raw,
    output logic [MEM_DATA_W-1:0] data_c
);

    always_comb begin
        data_c = raw;
        if (size == MEM_SIZE_BYTE) begin
            data_c = is_signed ? {{8{raw[7]}}, raw[7:0]} : {8'h00, raw[7:0]};
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit between the CPU datapath and the ram.
// Request side : I_req_valid/O_req_ready handshake, write/size/signed/addr/wdata.
// Response side: O_rsp_valid/I_rsp_ready handshake, O_rsp_data, O_rsp_err.
// RAM side     : O_ram_enable/write/size/addr/data_in, I_ram_data_out (registered).
// Illegal requests are answered with O_rsp_err and never touch the RAM.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_LIMIT = MEM_ADDR_LIMIT
)
(
    input  logic                  I_clk,
    input  logic                  I_reset_n,
    input  logic                  I_req_valid,
    output logic                  O_req_ready,
    input  logic                  I_req_write,
    input  logic [1:0]            I_req_size,
    input  logic                  I_req_signed,
    input  logic [MEM_ADDR_W-1:0] I_req_addr,
    input  logic [MEM_DATA_W-1:0] I_req_wdata,
    output logic                  O_rsp_valid,
    input  logic                  I_rsp_ready,
    output logic [MEM_DATA_W-1:0] O_rsp_data,
    output logic                  O_rsp_err,
    output logic                  O_ram_enable,
    output logic                  O_ram_write,
    output logic [1:0]            O_ram_size,
    output logic [MEM_ADDR_W-1:0] O_ram_addr,
    output logic [MEM_DATA_W-1:0] O_ram_data_in,
    input  logic [MEM_DATA_W-1:0] I_ram_data_out
);

    // One extra bit so a limit of 2**MEM_ADDR_W still compares correctly
    localparam logic [MEM_ADDR_W:0] LIMIT = (MEM_ADDR_W+1)'(ADDR_LIMIT);

    mem_state_e            state_q;
    mem_ctl_t              ctl_q;
    logic                  err_q;
    logic                  req_err_c;
    logic [MEM_ADDR_W:0]   addr_ext_c;
    logic [MEM_DATA_W-1:0] load_data_c;

    // Range / size legality of the incoming request
    always_comb begin
        addr_ext_c = {1'b0, I_req_addr};
        req_err_c  = 1'b0;
        if ((I_req_size != MEM_SIZE_BYTE) && (I_req_size != MEM_SIZE_WORD)) begin
            req_err_c = 1'b1;
        end
        if (addr_ext_c >= LIMIT) begin
            req_err_c = 1'b1;
        end
        if ((I_req_size == MEM_SIZE_WORD) && (addr_ext_c == (LIMIT - (MEM_ADDR_W+1)'(1)))) begin
            req_err_c = 1'b1;
        end
    end

    mem_load_format u_fmt (
        .size      (ctl_q.size),
        .is_signed (ctl_q.sign),
        .raw       (I_ram_data_out),
        .data_c    (load_data_c)
    );

    // Request/response FSM; every output is a register
    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            state_q       <= ST_IDLE;
            ctl_q         <= '0;
            err_q         <= 1'b0;
            O_req_ready   <= 1'b0;
            O_rsp_valid   <= 1'b0;
            O_rsp_data    <= '0;
            O_rsp_err     <= 1'b0;
            O_ram_enable  <= 1'b0;
            O_ram_write   <= 1'b0;
            O_ram_size    <= '0;
            O_ram_addr    <= '0;
            O_ram_data_in <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    O_req_ready <= 1'b1;
                    if (I_req_valid && O_req_ready) begin
                        O_req_ready <= 1'b0;
                        ctl_q       <= '{write: I_req_write, size: I_req_size, sign: I_req_signed};
                        if (req_err_c) begin
                            err_q   <= 1'b1;
                            state_q <= ST_RESP;
                        end else begin
                            O_ram_enable  <= 1'b1;
                            O_ram_write   <= I_req_write;
                            O_ram_size    <= I_req_size;
                            O_ram_addr    <= I_req_addr;
                            O_ram_data_in <= !I_req_write ? '0 :
                                             (I_req_size == MEM_SIZE_WORD) ? I_req_wdata :
                                             {8'h00, I_req_wdata[7:0]};
                            state_q       <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    O_ram_enable  <= 1'b0;
                    O_ram_write   <= 1'b0;
                    O_ram_size    <= '0;
                    O_ram_addr    <= '0;
                    O_ram_data_in <= '0;
                    if (ctl_q.write) begin
                        O_rsp_valid <= 1'b1;
                        state_q     <= ST_RESP;
                    end else begin
                        state_q     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    O_rsp_data  <= load_data_c;
                    O_rsp_valid <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    // Error path arrives here without valid set; raise it one cycle later
                    if (!O_rsp_valid) begin
                        O_rsp_valid <= 1'b1;
                        O_rsp_err   <= err_q;
                    end else if (I_rsp_ready) begin
                        O_rsp_valid <= 1'b0;
                        O_rsp_data  <= '0;
                        O_rsp_err   <= 1'b0;
                        err_q       <= 1'b0;
                        O_req_ready <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a small byte RAM model.
module tb_mem_access_unit;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [15:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [15:0] rsp_data;
    logic        ram_enable, ram_write;
    logic [1:0]  ram_size;
    logic [15:0] ram_addr, ram_data_in, ram_data_out;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_LIMIT(2048)) dut (
        .I_clk          (clk),
        .I_reset_n      (reset_n),
        .I_req_valid    (req_valid),
        .O_req_ready    (req_ready),
        .I_req_write    (req_write),
        .I_req_size     (req_size),
        .I_req_signed   (req_signed),
        .I_req_addr     (req_addr),
        .I_req_wdata    (req_wdata),
        .O_rsp_valid    (rsp_valid),
        .I_rsp_ready    (rsp_ready),
        .O_rsp_data     (rsp_data),
        .O_rsp_err      (rsp_err),
        .O_ram_enable   (ram_enable),
        .O_ram_write    (ram_write),
        .O_ram_size     (ram_size),
        .O_ram_addr     (ram_addr),
        .O_ram_data_in  (ram_data_in),
        .I_ram_data_out (ram_data_out)
    );

    // Little-endian byte RAM with registered read; reads always return two bytes
    logic [7:0] mem [0:2047];
    logic [10:0] a0, a1;
    assign a0 = ram_addr[10:0];
    assign a1 = 11'(ram_addr[10:0] + 11'd1);

    always @(posedge clk) begin
        if (ram_enable) begin
            if (ram_write) begin
                mem[a0] <= ram_data_in[7:0];
                if (ram_size == MEM_SIZE_WORD) mem[a1] <= ram_data_in[15:8];
            end else begin
                ram_data_out <= {mem[a1], mem[a0]};
            end
        end
    end

    typedef struct {
        logic        write;
        logic [1:0]  size;
        logic        sgn;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_data;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic w, input logic [1:0] s, input logic sg,
                                input logic [15:0] a, input logic [15:0] wd,
                                input logic [15:0] ed, input logic ee, input int el);
        vec_t v;
        v.write = w; v.size = s; v.sgn = sg; v.addr = a; v.wdata = wd;
        v.exp_data = ed; v.exp_err = ee; v.exp_lat = el;
        return v;
    endfunction

    // Called #1 after the accept edge; counts enable cycles until rsp_valid (bounded)
    task automatic wait_rsp(output int lat, output int en_cnt);
        en_cnt = int'(ram_enable);
        lat    = -1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (rsp_valid) begin
                lat = k;
                break;
            end
            en_cnt += int'(ram_enable);
        end
    endtask

    task automatic drive(input vec_t v);
        req_valid  = 1'b1;
        req_write  = v.write;
        req_size   = v.size;
        req_signed = v.sgn;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
    endtask

    task automatic handshake(input string tag);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({tag, "_rsp_cleared"}, {rsp_valid, rsp_err, rsp_data}, 32'h0);
        check({tag, "_ready_back"}, req_ready, 1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int    lat, en;
        string t;
        t = $sformatf("v%0d", idx);
        @(negedge clk);
        check({t, "_ready_idle"}, req_ready, 1);
        drive(v);
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_rsp(lat, en);
        check({t, "_latency"}, lat, v.exp_lat);
        check({t, "_enables"}, en, v.exp_err ? 0 : 1);
        check({t, "_data"}, rsp_data, v.exp_data);
        check({t, "_err"}, rsp_err, v.exp_err);
        check({t, "_ready_busy"}, req_ready, 0);
        handshake(t);
    endtask

    vec_t vecs [13];

    initial begin
        int lat, en;

        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
        mem[1] = 8'h80;
        mem[2] = 8'hFF;
        ram_data_out = 16'h0;

        reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_signed = 1'b0; req_addr = 16'h0; req_wdata = 16'h0; rsp_ready = 1'b0;

        //            wr    size  sgn   addr      wdata     exp_data  err   lat
        vecs[0]  = mk(1'b0, 2'd2, 1'b0, 16'h0000, 16'h0000, 16'h8000, 1'b0, 2);
        vecs[1]  = mk(1'b0, 2'd1, 1'b1, 16'h0001, 16'h0000, 16'hFF80, 1'b0, 2);
        vecs[2]  = mk(1'b0, 2'd1, 1'b0, 16'h0001, 16'h0000, 16'h0080, 1'b0, 2);
        vecs[3]  = mk(1'b1, 2'd2, 1'b0, 16'h0100, 16'h1234, 16'h0000, 1'b0, 1);
        vecs[4]  = mk(1'b0, 2'd1, 1'b0, 16'h0101, 16'h0000, 16'h0012, 1'b0, 2);
        vecs[5]  = mk(1'b0, 2'd2, 1'b0, 16'h07FF, 16'h0000, 16'h0000, 1'b1, 1);
        vecs[6]  = mk(1'b0, 2'd1, 1'b0, 16'h0800, 16'h0000, 16'h0000, 1'b1, 1);
        vecs[7]  = mk(1'b0, 2'd0, 1'b0, 16'h0010, 16'h0000, 16'h0000, 1'b1, 1);
        vecs[8]  = mk(1'b1, 2'd1, 1'b0, 16'h0200, 16'hABCD, 16'h0000, 1'b0, 1);
        vecs[9]  = mk(1'b0, 2'd2, 1'b0, 16'h0200, 16'h0000, 16'h00CD, 1'b0, 2);
        vecs[10] = mk(1'b0, 2'd1, 1'b1, 16'h0101, 16'h0000, 16'h0012, 1'b0, 2);
        vecs[11] = mk(1'b0, 2'd1, 1'b0, 16'h07FF, 16'h0000, 16'h0000, 1'b0, 2);
        vecs[12] = mk(1'b1, 2'd3, 1'b0, 16'h0000, 16'h5555, 16'h0000, 1'b1, 1);

        // Reset state
        @(negedge clk); @(negedge clk);
        check("reset_outputs", {req_ready, rsp_valid, rsp_err, ram_enable, ram_write, ram_size},
              32'h0);
        check("reset_buses", {rsp_data, ram_addr}, 32'h0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_reset", req_ready, 1);

        for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

        // Response held under back-pressure while another request waits
        @(negedge clk);
        drive(vecs[0]);
        @(posedge clk); #1;
        drive(vecs[2]);
        wait_rsp(lat, en);
        check("hold_latency", lat, 2);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check($sformatf("hold%0d_state", c), {rsp_valid, req_ready, rsp_err, ram_enable}, 32'h8);
            check($sformatf("hold%0d_data", c), rsp_data, 16'h8000);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("hold_release", {req_ready, rsp_valid, ram_enable}, 32'h4);
        @(posedge clk); #1;
        check("next_accept_enable", ram_enable, 1);
        check("next_accept_addr", ram_addr, 16'h0001);
        req_valid = 1'b0;
        wait_rsp(lat, en);
        check("next_latency", lat, 2);
        check("next_enables", en, 1);
        check("next_data", rsp_data, 16'h0080);
        handshake("next");

        // Asynchronous reset while the load sits in WAIT
        @(negedge clk);
        drive(vecs[9]);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_outputs", {req_ready, rsp_valid, rsp_err, ram_enable, ram_write, ram_size},
              32'h0);
        check("async_reset_buses", {rsp_data, ram_addr}, 32'h0);
        check("async_reset_wdata", ram_data_in, 16'h0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check($sformatf("post_reset%0d_no_rsp", c), rsp_valid, 0);
        end
        check("post_reset_ready", req_ready, 1);
        run_vec(mk(1'b0, 2'd2, 1'b0, 16'h0100, 16'h0000, 16'h1234, 1'b0, 2), 99);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
